// File: rtl/cbus_arbiter_n.sv
// Burst-locked N-master cache-bus arbiter (fixed or round-robin); 1-cycle arbitration, mandatory IDLE bubble between grants.
// Only the owner sees oresp; others get ready=0 until the owner's ready&&last, so a granted burst cannot be interrupted.
package common;
   typedef enum logic [7:0] {
      MLEN1  = 8'd0,
      MLEN2  = 8'd1,
      MLEN4  = 8'd3,
      MLEN8  = 8'd7,
      MLEN16 = 8'd15
   } mlen_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strb;
      logic [63:0] data;
      mlen_t       len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter_n
   import common::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter bit ROUND_ROBIN = 1'b1,
   parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  cbus_req_t        ireqs  [NUM_MASTERS],
   output cbus_resp_t       iresps [NUM_MASTERS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             done;

   // k-th candidate in scan order: rotated from rr_ptr in round-robin, plain index otherwise
   function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int k);
      if (ROUND_ROBIN) return IDX_W'((int'(base) + k) % NUM_MASTERS);
      return IDX_W'(k);
   endfunction

   // Scan from the far end so the earliest candidate in scan order is written last and wins
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (ireqs[slot(rr_ptr, k)].valid) begin
            pick_vld = 1'b1;
            pick_idx = slot(rr_ptr, k);
         end
      end
   end

   assign done = oresp.ready && oresp.last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx_q  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         idx_q  <= idx_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx_q;
      rr_ptr_nxt = rr_ptr;
      oreq       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) iresps[i] = '0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = BUSY;
               idx_nxt   = pick_idx;
            end
         end
         BUSY: begin
            oreq = ireqs[idx_q];
            for (int i = 0; i < NUM_MASTERS; i++) begin
               if (idx_q == IDX_W'(i)) iresps[i] = oresp;
            end
            if (done) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               if (ROUND_ROBIN) rr_ptr_nxt = IDX_W'((int'(idx_q) + 1) % NUM_MASTERS);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant_valid = (state == BUSY);
   assign grant_idx   = idx_q;

   // The owner must keep valid asserted until its burst completes
   a_owner_valid: assert property (@(posedge clk) disable iff (reset) (state == BUSY) |-> oreq.valid);
endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Bench for cbus_arbiter_n: round-robin and fixed-priority instances share stimulus and are
// compared every cycle against a grant/pointer model, plus directed burst, lock and reset scenarios.
module tb_cbus_arbiter_n;
   import common::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  ireqs [N];
   cbus_resp_t oresp;
   cbus_resp_t iresps_rr [N];
   cbus_resp_t iresps_fp [N];
   cbus_req_t  oreq_rr, oreq_fp;
   logic       gv_rr, gv_fp;
   logic [1:0] gi_rr, gi_fp;

   always #5 clk = ~clk;

   cbus_arbiter_n #(.NUM_MASTERS(N), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_rr),
      .oreq(oreq_rr), .oresp(oresp), .grant_valid(gv_rr), .grant_idx(gi_rr));

   cbus_arbiter_n #(.NUM_MASTERS(N), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps_fp),
      .oreq(oreq_fp), .oresp(oresp), .grant_valid(gv_fp), .grant_idx(gi_fp));

   int n_chk  = 0;
   int n_pass = 0;

   // reference state per instance: 0 = round-robin, 1 = fixed priority
   bit busy  [2];
   int owner [2];
   int ptr   [2];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         busy[m]  = 1'b0;
         owner[m] = 0;
         ptr[m]   = 0;
      end
   endtask

   // Winner = valid master at the smallest distance from the pointer (RR) or lowest index (fixed)
   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         if (busy[m]) begin
            if (oresp.ready && oresp.last) begin
               busy[m] = 1'b0;
               if (m == 0) ptr[m] = (owner[m] + 1) % N;
               owner[m] = 0;
            end
         end else begin
            int best  = -1;
            int bestd = N;
            for (int i = 0; i < N; i++) begin
               if (ireqs[i].valid) begin
                  int d = (m == 0) ? (i - ptr[m] + N) % N : i;
                  if (d < bestd) begin
                     bestd = d;
                     best  = i;
                  end
               end
            end
            if (best >= 0) begin
               busy[m]  = 1'b1;
               owner[m] = best;
            end
         end
      end
   endtask

   function automatic bit held(input int i);
      return (busy[0] && owner[0] == i) || (busy[1] && owner[1] == i);
   endfunction

   task automatic compare_all(input string tag);
      chk({tag, "/gv_rr"}, 256'(gv_rr), 256'(busy[0]));
      chk({tag, "/gi_rr"}, 256'(gi_rr), busy[0] ? 256'(owner[0]) : 256'(0));
      chk({tag, "/oreq_rr"}, 256'(oreq_rr), busy[0] ? 256'(ireqs[owner[0]]) : 256'(0));
      chk({tag, "/gv_fp"}, 256'(gv_fp), 256'(busy[1]));
      chk({tag, "/gi_fp"}, 256'(gi_fp), busy[1] ? 256'(owner[1]) : 256'(0));
      chk({tag, "/oreq_fp"}, 256'(oreq_fp), busy[1] ? 256'(ireqs[owner[1]]) : 256'(0));
      for (int i = 0; i < N; i++) begin
         chk({tag, $sformatf("/iresp_rr%0d", i)}, 256'(iresps_rr[i]),
             (busy[0] && owner[0] == i) ? 256'(oresp) : 256'(0));
         chk({tag, $sformatf("/iresp_fp%0d", i)}, 256'(iresps_fp[i]),
             (busy[1] && owner[1] == i) ? 256'(oresp) : 256'(0));
      end
   endtask

   // Inputs are stable from posedge+1; compare at negedge, then advance the model to the next edge
   task automatic step(input string tag);
      @(negedge clk);
      compare_all(tag);
      model_update();
      @(posedge clk);
      #1;
   endtask

   function automatic cbus_req_t rand_req();
      cbus_req_t r;
      r.valid    = 1'($urandom_range(1));
      r.is_write = 1'($urandom_range(1));
      r.size     = 3'($urandom_range(7));
      r.addr     = {$urandom, $urandom};
      r.strb     = 8'($urandom);
      r.data     = {$urandom, $urandom};
      r.len      = mlen_t'(8'($urandom_range(15)));
      r.burst    = 2'($urandom_range(3));
      return r;
   endfunction

   function automatic cbus_req_t mk_req(input logic [63:0] addr, input mlen_t len);
      cbus_req_t r;
      r          = rand_req();
      r.valid    = 1'b1;
      r.is_write = 1'b0;
      r.addr     = addr;
      r.len      = len;
      return r;
   endfunction

   task automatic set_beat(input logic ready, input logic last);
      oresp.ready = ready;
      oresp.last  = last;
      oresp.data  = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      reset = 1'b1;
      oresp = '0;
      for (int i = 0; i < N; i++) ireqs[i] = '0;
      model_reset();
      @(posedge clk);
      #1;
      compare_all("reset");
      chk("reset/rr_ptr", 256'(dut_rr.rr_ptr), 256'(0));
      reset = 1'b0;
   endtask

   initial begin
      // single MLEN4 read from master 2
      do_reset();
      ireqs[2] = mk_req(64'h0000_0000_1000_0040, MLEN4);
      step("t1_arb");
      chk("t1_gidx", 256'(gi_rr), 256'(2));
      chk("t1_addr", 256'(oreq_rr.addr), 256'(64'h0000_0000_1000_0040));
      for (int b = 0; b < 4; b++) begin
         set_beat(1'b1, b == 3);
         step("t1_beat");
      end
      chk("t1_gv_after_last", 256'(gv_rr), 256'(0));
      chk("t1_rr_ptr", 256'(dut_rr.rr_ptr), 256'(3));
      ireqs[2] = '0;
      oresp    = '0;
      step("t1_bubble");

      // all masters valid, single-beat bursts
      do_reset();
      for (int i = 0; i < N; i++) ireqs[i] = mk_req(64'(i) << 12, MLEN1);
      for (int g = 0; g < 5; g++) begin
         oresp = '0;
         step("t2_idle");
         chk($sformatf("t2_rr_order%0d", g), 256'(gi_rr), 256'(g % 4));
         chk($sformatf("t2_fp_order%0d", g), 256'(gi_fp), 256'(0));
         set_beat(1'b1, 1'b1);
         step("t2_beat");
         chk($sformatf("t2_bubble%0d", g), 256'(gv_rr), 256'(0));
      end
      oresp          = '0;
      ireqs[0].valid = 1'b0;
      step("t3_drop0");
      chk("t3_fp_next", 256'(gi_fp), 256'(1));
      chk("t3_rr_next", 256'(gi_rr), 256'(1));
      set_beat(1'b1, 1'b1);
      step("t3_beat");

      // lock: master 0 waits behind master 1; ready gaps without last keep the grant
      do_reset();
      ireqs[1] = mk_req(64'h2000, MLEN4);
      step("t4_arb");
      ireqs[0] = mk_req(64'h3000, MLEN1);
      for (int b = 0; b < 6; b++) begin
         set_beat(b % 2 == 0 || b == 5, b == 5);
         #1;
         chk($sformatf("t4_blocked_rr%0d", b), 256'(iresps_rr[0].ready), 256'(0));
         chk($sformatf("t4_blocked_fp%0d", b), 256'(iresps_fp[0].ready), 256'(0));
         if (oresp.ready) chk($sformatf("t4_data%0d", b), 256'(iresps_rr[1].data), 256'(oresp.data));
         chk($sformatf("t4_held%0d", b), 256'(gi_rr), 256'(1));
         step("t4_beat");
      end
      oresp          = '0;
      ireqs[1].valid = 1'b0;
      step("t4_rearb");
      chk("t4_rr_m0", 256'(gi_rr), 256'(0));
      chk("t4_fp_m0", 256'(gi_fp), 256'(0));
      set_beat(1'b1, 1'b1);
      step("t4_done");
      ireqs[0] = '0;
      oresp    = '0;

      // reset in the middle of an MLEN8 burst
      ireqs[3] = mk_req(64'h4000, MLEN8);
      step("t6_arb");
      chk("t6_ptr_before", 256'(dut_rr.rr_ptr), 256'(ptr[0]));
      set_beat(1'b1, 1'b0);
      step("t6_beat1");
      set_beat(1'b1, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_oreq_zero", 256'(oreq_rr), 256'(0));
      chk("t6_gv_zero", 256'(gv_rr), 256'(0));
      chk("t6_ptr_zero", 256'(dut_rr.rr_ptr), 256'(0));
      model_reset();
      for (int i = 0; i < N; i++) ireqs[i] = '0;
      oresp = '0;
      compare_all("t6_in_reset");
      #1;
      reset    = 1'b0;
      ireqs[2] = mk_req(64'h5000, MLEN1);
      step("t6_fresh");
      chk("t6_fresh_gv", 256'(gv_rr), 256'(1));
      chk("t6_fresh_gi", 256'(gi_rr), 256'(2));
      set_beat(1'b1, 1'b1);
      step("t6_done");

      // randomized traffic; a master keeps valid while either instance owns it
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            ireqs[i] = rand_req();
            if (held(i)) ireqs[i].valid = 1'b1;
         end
         oresp.ready = 1'($urandom_range(1));
         oresp.last  = ($urandom_range(2) == 0);
         oresp.data  = {$urandom, $urandom};
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
